// File: rtl/seg7_pkg.sv
// Shared types, glyph codes and the name table for the seven-segment marquee.
// Glyph bit order is a..g from bit 0 upward, active-high.
package seg7_pkg;

    typedef enum logic [1:0] {
        SCROLL = 2'd0,
        HOLD   = 2'd1,
        STEP   = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;  // lower-case b
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;  // lower-case d
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_I     = 7'h06;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_N     = 7'h54;  // lower-case n
    localparam logic [6:0] SEG_O     = 7'h3F;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_R     = 7'h50;  // lower-case r
    localparam logic [6:0] SEG_S     = 7'h6D;
    localparam logic [6:0] SEG_T     = 7'h78;  // lower-case t
    localparam logic [6:0] SEG_U     = 7'h3E;

    localparam int unsigned NAME_TABLE_SIZE = 8;
    localparam int unsigned NAME_MAX_LEN    = 8;

    localparam logic [6:0] NAME_GLYPHS [0:NAME_TABLE_SIZE-1][0:NAME_MAX_LEN-1] = '{
        '{SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_A, SEG_L, SEG_I, SEG_C, SEG_E, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_B, SEG_O, SEG_B, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_P, SEG_E, SEG_T, SEG_E, SEG_R, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_C, SEG_A, SEG_T, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_S, SEG_U, SEG_N, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_F, SEG_R, SEG_E, SEG_D, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{SEG_H, SEG_I, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK}
    };

    localparam logic [3:0] NAME_LEN [0:NAME_TABLE_SIZE-1] = '{
        4'd5, 4'd5, 4'd3, 4'd5, 4'd3, 4'd3, 4'd4, 4'd2
    };

endpackage

// File: rtl/seg7_name_rom.sv
// Combinational name lookup: glyph at a character position and the index of
// the last character. Positions past the end of a name read as blank.
module seg7_name_rom
    import seg7_pkg::*;
#(
    parameter int unsigned NAME_W = 3,
    parameter int unsigned POS_W  = 5
) (
    input  logic [NAME_W-1:0] name,
    input  logic [POS_W-1:0]  position,
    output logic [6:0]        glyph,
    output logic [POS_W-1:0]  last
);

    logic [2:0]       idx;
    logic [2:0]       chr;
    logic [3:0]       len;
    logic [POS_W+3:0] pos_w;
    logic [POS_W+3:0] len_w;

    // Names beyond the table size alias onto it.
    assign idx   = 3'(name);
    assign chr   = 3'(position);
    assign len   = NAME_LEN[idx];
    assign pos_w = (POS_W + 4)'(position);
    assign len_w = (POS_W + 4)'(len);
    assign last  = POS_W'(len - 4'd1);

    always_comb begin
        glyph = SEG_BLANK;
        if (pos_w < len_w) begin
            glyph = NAME_GLYPHS[idx][chr];
        end
    end

endmodule

// File: rtl/seg7_marquee.sv
// Seven-segment name scroller with programmable tick divider and run modes.
// Define SEG7_DP_LAST_EN to light dp on the last character of a name.
module seg7_marquee
    import seg7_pkg::*;
#(
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned MAX_COUNT  = 10_000_000,
    parameter int unsigned TICK_SHIFT = 18,
    parameter int unsigned NAME_W     = 3,
    parameter int unsigned POS_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NAME_W-1:0] name,
    input  logic [5:0]        period_sel,
    input  logic [1:0]        mode,
    input  logic              step,
    output logic [6:0]        segments,
    output logic              dp,
    output logic [POS_W-1:0]  position,
    output logic              wrap,
    output logic [7:0]        tick_lsb
);

    mode_e             mode_cur;
    logic [DIV_W-1:0]  compare;
    logic [DIV_W-1:0]  sel_ext;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              phase_q, phase_d;
    logic              wrap_q, wrap_d;
    logic [6:0]        seg_q, seg_d;
    logic [NAME_W-1:0] prev_name_q;
    logic              step_s1_q, step_s2_q;

    logic              name_chg;
    logic              step_rise;
    logic              cnt_hit;
    logic              tick;
    logic              adv;
    logic              at_last;

    logic [6:0]        rom_glyph;
    logic [POS_W-1:0]  rom_last;

    assign mode_cur = mode_e'(mode);
    assign sel_ext  = DIV_W'(period_sel);
    assign compare  = (period_sel == '0) ? DIV_W'(MAX_COUNT) : (sel_ext << TICK_SHIFT);

    seg7_name_rom #(
        .NAME_W (NAME_W),
        .POS_W  (POS_W)
    ) u_rom (
        .name     (name),
        .position (pos_q),
        .glyph    (rom_glyph),
        .last     (rom_last)
    );

    assign name_chg  = (name != prev_name_q);
    // step is sampled once, then edge-detected against the sample before it.
    assign step_rise = step_s1_q & ~step_s2_q;
    assign cnt_hit   = (cnt_q >= compare);
    assign at_last   = (pos_q >= rom_last);

    always_comb begin
        tick = 1'b0;
        adv  = 1'b0;
        if (!name_chg) begin
            case (mode_cur)
                SCROLL: begin
                    tick = cnt_hit;
                    adv  = cnt_hit;
                end
                BLINK:   tick = cnt_hit;
                STEP:    adv  = step_rise;
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        wrap_d  = wrap_q;
        seg_d   = seg_q;
        if (ena) begin
            seg_d = phase_q ? SEG_BLANK : rom_glyph;
            if (name_chg) begin
                cnt_d   = '0;
                pos_d   = '0;
                phase_d = 1'b0;
                wrap_d  = 1'b0;
            end else begin
                wrap_d = adv & at_last;
                if (adv) begin
                    pos_d = at_last ? '0 : pos_q + 1'b1;
                end
                case (mode_cur)
                    HOLD:    cnt_d = cnt_q;
                    STEP:    cnt_d = '0;
                    default: cnt_d = tick ? '0 : cnt_q + 1'b1;
                endcase
                phase_d = (mode_cur == BLINK) ? (phase_q ^ tick) : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pos_q   <= '0;
            phase_q <= 1'b0;
            wrap_q  <= 1'b0;
            seg_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    // Name and step history keep tracking the inputs even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_name_q <= '0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
        end else begin
            prev_name_q <= name;
            step_s1_q   <= step;
            step_s2_q   <= step_s1_q;
        end
    end

`ifdef SEG7_DP_LAST_EN
    logic dp_q, dp_d;

    always_comb begin
        dp_d = dp_q;
        if (ena) begin
            dp_d = (pos_q == rom_last) & ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp = ena & dp_q;
`else
    assign dp = 1'b0;
`endif

    assign segments = ena ? seg_q : '0;
    assign position = pos_q;
    assign wrap     = wrap_q;
    assign tick_lsb = 8'(cnt_q);

endmodule

// File: tb/tb_seg7_marquee.sv
// Scoreboard bench for seg7_marquee: a cycle model queues expected outputs at
// each clock edge and they are compared half a cycle later, plus directed checks.
module tb_seg7_marquee;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] name;
    logic [5:0] period_sel;
    logic [1:0] mode;
    logic       step;
    logic [6:0] segments;
    logic       dp;
    logic [4:0] position;
    logic       wrap;
    logic [7:0] tick_lsb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    seg7_marquee #(
        .DIV_W      (8),
        .MAX_COUNT  (4),
        .TICK_SHIFT (2),
        .NAME_W     (3),
        .POS_W      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .name       (name),
        .period_sel (period_sel),
        .mode       (mode),
        .step       (step),
        .segments   (segments),
        .dp         (dp),
        .position   (position),
        .wrap       (wrap),
        .tick_lsb   (tick_lsb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    string NAMES [8] = '{"HELLO", "ALICE", "bOb", "PEtEr", "CAt", "SUn", "FrEd", "HI"};

    function automatic logic [6:0] char2seg(input byte c);
        case (c)
            "A": return 7'h77;
            "b": return 7'h7C;
            "C": return 7'h39;
            "d": return 7'h5E;
            "E": return 7'h79;
            "F": return 7'h71;
            "H": return 7'h76;
            "I": return 7'h06;
            "L": return 7'h38;
            "n": return 7'h54;
            "O": return 7'h3F;
            "P": return 7'h73;
            "r": return 7'h50;
            "S": return 7'h6D;
            "t": return 7'h78;
            "U": return 7'h3E;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] ref_glyph(input int n, input int unsigned p);
        if (p < NAMES[n].len()) return char2seg(NAMES[n][p]);
        return 7'h00;
    endfunction

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [4:0] pos;
        logic       wrap;
        logic [7:0] lsb;
    } exp_t;

    exp_t exp_q[$];

    int unsigned m_cnt, m_pos, m_last, m_cmp;
    bit          m_phase, m_wrap, m_dp, m_s1, m_s2, m_tick, m_adv, m_rise;
    logic [6:0]  m_seg;
    logic [2:0]  m_prev;

    task automatic model_edge();
        exp_t e;
        if (!rst_n) begin
            m_cnt = 0; m_pos = 0; m_phase = 0; m_wrap = 0; m_dp = 0;
            m_seg = 7'h00; m_prev = 3'd0; m_s1 = 0; m_s2 = 0;
            exp_q.delete();
            return;
        end
        m_cmp  = (period_sel == 0) ? 4 : ((int'(period_sel) * 4) % 256);
        m_last = NAMES[int'(name)].len() - 1;
        m_rise = m_s1 && !m_s2;
        if (ena) begin
            m_seg = m_phase ? 7'h00 : ref_glyph(int'(name), m_pos);
`ifdef SEG7_DP_LAST_EN
            m_dp = (m_pos == m_last) && !m_phase;
`else
            m_dp = 0;
`endif
            if (name != m_prev) begin
                m_cnt = 0; m_pos = 0; m_phase = 0; m_wrap = 0;
            end else begin
                m_tick = (mode == 2'd0 || mode == 2'd3) && (m_cnt >= m_cmp);
                m_adv  = (mode == 2'd0) ? m_tick : (mode == 2'd2) ? m_rise : 1'b0;
                m_wrap = m_adv && (m_pos >= m_last);
                if (m_adv) m_pos = (m_pos >= m_last) ? 0 : m_pos + 1;
                if (mode == 2'd2) m_cnt = 0;
                else if (mode != 2'd1) m_cnt = m_tick ? 0 : m_cnt + 1;
                m_phase = (mode == 2'd3) ? (m_phase ^ m_tick) : 1'b0;
            end
        end
        m_prev = name;
        m_s2   = m_s1;
        m_s1   = step;
        e.seg  = ena ? m_seg : 7'h00;
        e.dp   = ena ? m_dp : 1'b0;
        e.pos  = m_pos[4:0];
        e.wrap = m_wrap;
        e.lsb  = m_cnt[7:0];
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_edge();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_segments", 32'(segments), 32'(e.seg));
            check("sb_dp",       32'(dp),       32'(e.dp));
            check("sb_position", 32'(position), 32'(e.pos));
            check("sb_wrap",     32'(wrap),     32'(e.wrap));
            check("sb_tick_lsb", 32'(tick_lsb), 32'(e.lsb));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          found;
        int unsigned zeros, dps;

        rst_n = 1'b0; ena = 1'b1; name = 3'd0; period_sel = 6'd0;
        mode = 2'd0; step = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_segments", 32'(segments), 0);
        check("rst_dp",       32'(dp),       0);
        check("rst_position", 32'(position), 0);
        check("rst_wrap",     32'(wrap),     0);
        check("rst_tick_lsb", 32'(tick_lsb), 0);
        #1 rst_n = 1'b1;

        // Default period: one character every 5 clocks, wrap on 4 -> 0.
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k % 5 == 0) begin
                check("scroll_pos",  32'(position), 32'((k / 5) % 5));
                check("scroll_wrap", 32'(wrap),     (k == 25) ? 1 : 0);
            end
        end

        // Name switch coinciding with a tick at position 3.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (position == 5'd3 && tick_lsb == 8'd4) found = 1;
        end
        check("wait_pos3_tick", 32'(found), 1);
        #1 name = 3'd1;
        @(negedge clk);
        check("namesw_pos",  32'(position), 0);
        check("namesw_cnt",  32'(tick_lsb), 0);
        check("namesw_wrap", 32'(wrap),     0);

        // Period 12 -> 4 while the counter sits at 9.
        #1 period_sel = 6'd3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (tick_lsb == 8'd9) found = 1;
        end
        check("wait_cnt9", 32'(found), 1);
        #1 period_sel = 6'd1;
        @(negedge clk);
        check("shrink_cnt", 32'(tick_lsb), 0);

        // STEP with three pulses, then HOLD.
        #1 mode = 2'd2; name = 3'd3; period_sel = 6'd0;
        repeat (2) @(negedge clk);
        check("step_start_pos", 32'(position), 0);
        for (int p = 0; p < 3; p++) begin
            #1 step = 1'b1;
            repeat (2) @(negedge clk);
            #1 step = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("step_pos", 32'(position), 3);
        check("step_cnt", 32'(tick_lsb), 0);
        #1 mode = 2'd1;
        repeat (50) @(negedge clk);
        check("hold_pos", 32'(position), 3);
        check("hold_cnt", 32'(tick_lsb), 0);

        // One more step to the last character, then BLINK.
        #1 mode = 2'd2; step = 1'b1;
        repeat (2) @(negedge clk);
        #1 step = 1'b0;
        repeat (2) @(negedge clk);
        check("step_last_pos", 32'(position), 4);
        #1 mode = 2'd3;
        zeros = 0; dps = 0;
        repeat (40) begin
            @(negedge clk);
            if (segments == 7'h00) zeros++;
            if (dp) dps++;
        end
        check("blink_pos",   32'(position), 4);
        check("blink_zeros", zeros, 20);
`ifdef SEG7_DP_LAST_EN
        check("blink_dp", dps, 20);
`else
        check("blink_dp", dps, 0);
`endif

        // Asynchronous reset mid-scroll.
        #1 mode = 2'd0; name = 3'd0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_segments", 32'(segments), 0);
        check("arst_dp",       32'(dp),       0);
        check("arst_position", 32'(position), 0);
        check("arst_wrap",     32'(wrap),     0);
        check("arst_tick_lsb", 32'(tick_lsb), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (7) @(negedge clk);
        check("run_pos", 32'(position), 1);
        check("run_cnt", 32'(tick_lsb), 2);

        // Disabled for 20 cycles: blank outputs, state held.
        #1 ena = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("dis_segments", 32'(segments), 0);
            check("dis_dp",       32'(dp),       0);
            check("dis_position", 32'(position), 1);
            check("dis_cnt",      32'(tick_lsb), 2);
        end
        #1 ena = 1'b1;

        // Random traffic against the model.
        repeat (400) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) name = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)  mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) period_sel = 6'($urandom_range(0, 3));
            step = 1'($urandom_range(0, 1));
            ena  = ($urandom_range(0, 9) != 0);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
